// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures the high time of a servo PWM pulse train in clk
// cycles, reports accepted widths, gripper open/close decode, malformed pulses
// and loss of signal.
module servo_pwm_decoder #(
  parameter int unsigned MIN_W   = 6000,
  parameter int unsigned MAX_W   = 30000,
  parameter int unsigned THRESH  = 18000,
  parameter int unsigned TIMEOUT = 480000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [17:0] pos,
  output logic        valid,
  output logic        open_det,
  output logic        present,
  output logic        err_short,
  output logic        err_long
);

  localparam int unsigned WW = 18;
  localparam int unsigned TW = 20;

  localparam logic [WW-1:0] MIN_C    = WW'(MIN_W);
  localparam logic [WW-1:0] MAX_C    = WW'(MAX_W);
  localparam logic [WW-1:0] THRESH_C = WW'(THRESH);
  localparam logic [TW-1:0] TO_C     = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ARM_WAIT = 2'd0,
    LOW      = 2'd1,
    HIGH     = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          s_meta, s, s_d;
  logic          rise, fall;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [WW-1:0] pos_n;
  logic          open_n, valid_n, present_n, err_short_n, err_long_n;
  logic          accept;

  // Two-flop synchronizer plus edge-detect delay. Reset to 1 so a line that is
  // already high at reset release is never mistaken for a fresh rising edge;
  // ARM_WAIT only proceeds once a genuine low has come through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
      s_d    <= 1'b1;
    end else begin
      s_meta <= pwm_in;
      s      <= s_meta;
      s_d    <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARM_WAIT;
      wcnt      <= '0;
      tcnt      <= '0;
      pos       <= '0;
      open_det  <= 1'b0;
      valid     <= 1'b0;
      present   <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      tcnt      <= tcnt_n;
      pos       <= pos_n;
      open_det  <= open_n;
      valid     <= valid_n;
      present   <= present_n;
      err_short <= err_short_n;
      err_long  <= err_long_n;
    end
  end

  // Next-state, width measurement and pulse classification.
  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    pos_n       = pos;
    open_n      = open_det;
    valid_n     = 1'b0;
    err_short_n = 1'b0;
    err_long_n  = 1'b0;
    accept      = 1'b0;

    case (state)
      ARM_WAIT: begin
        if (!s) state_n = LOW;
      end
      LOW: begin
        if (rise) begin
          wcnt_n  = WW'(1);
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          if (wcnt >= MIN_C) begin
            accept  = 1'b1;
            pos_n   = wcnt;
            open_n  = (wcnt < THRESH_C);
            valid_n = 1'b1;
          end else begin
            err_short_n = 1'b1;
          end
          state_n = LOW;
        end else if (wcnt == MAX_C) begin
          err_long_n = 1'b1;
          state_n    = ARM_WAIT;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      default: state_n = ARM_WAIT;
    endcase
  end

  // Signal-loss timer; an accept on the timeout cycle keeps present high.
  always_comb begin
    tcnt_n    = tcnt;
    present_n = present;
    if (tcnt == TO_C) begin
      present_n = 1'b0;
    end else begin
      tcnt_n = tcnt + TW'(1);
    end
    if (accept) begin
      tcnt_n    = '0;
      present_n = 1'b1;
    end
  end

endmodule
